// File: rtl/gpr_wb_unit.sv
// Writeback front-end for the GPR: merges LSU/ALU result writes into an in-order
// queue, drains one write per cycle to the GPR port, and offers operand forwarding.
module gpr_wb_unit #(
    parameter int GPR_WIDTH = 32,
    parameter int GPR_DEPTH = 5,
    parameter int Q_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [GPR_DEPTH-1:0] lsu_addr,
    input  logic [GPR_WIDTH-1:0] lsu_data,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [GPR_DEPTH-1:0] alu_addr,
    input  logic [GPR_WIDTH-1:0] alu_data,
    output logic                 gpr_wr,
    output logic [GPR_DEPTH-1:0] gpr_waddr,
    output logic [GPR_WIDTH-1:0] gpr_wd,
    input  logic [GPR_DEPTH-1:0] fwd_addr0,
    input  logic [GPR_DEPTH-1:0] fwd_addr1,
    output logic                 fwd_hit0,
    output logic                 fwd_hit1,
    output logic [GPR_WIDTH-1:0] fwd_data0,
    output logic [GPR_WIDTH-1:0] fwd_data1,
    output logic                 wb_idle
);
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [GPR_DEPTH-1:0] addr_q [Q_DEPTH];
    logic [GPR_DEPTH-1:0] addr_d [Q_DEPTH];
    logic [GPR_WIDTH-1:0] data_q [Q_DEPTH];
    logic [GPR_WIDTH-1:0] data_d [Q_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d, alu_slot_s;
    logic [CNT_W-1:0]     count_q, count_d, free_s;
    logic                 gpr_wr_q, gpr_wr_d;
    logic [GPR_DEPTH-1:0] gpr_waddr_q, gpr_waddr_d;
    logic [GPR_WIDTH-1:0] gpr_wd_q, gpr_wd_d;
    logic                 push_lsu_s, push_alu_s, pop_s;

    // Handshake: credit only the registered occupancy; LSU has priority on the last slot.
    always_comb begin
        free_s = CNT_W'(Q_DEPTH) - count_q;
        if (rst) begin
            lsu_ready = 1'b0;
            alu_ready = 1'b0;
        end else begin
            lsu_ready = (free_s >= CNT_W'(1));
            alu_ready = (free_s >= CNT_W'(2)) || ((free_s == CNT_W'(1)) && !lsu_valid);
        end
        push_lsu_s = lsu_valid && lsu_ready;
        push_alu_s = alu_valid && alu_ready;
        pop_s      = (count_q != '0);
    end

    // Queue and output-stage next state; the LSU entry lands in the older slot.
    always_comb begin
        alu_slot_s = tail_q + PTR_W'(push_lsu_s);
        for (int i = 0; i < Q_DEPTH; i++) begin
            addr_d[i] = (push_lsu_s && (tail_q == PTR_W'(i))) ? lsu_addr :
                        (push_alu_s && (alu_slot_s == PTR_W'(i))) ? alu_addr : addr_q[i];
            data_d[i] = (push_lsu_s && (tail_q == PTR_W'(i))) ? lsu_data :
                        (push_alu_s && (alu_slot_s == PTR_W'(i))) ? alu_data : data_q[i];
        end
        tail_d      = tail_q + PTR_W'(push_lsu_s) + PTR_W'(push_alu_s);
        head_d      = head_q + PTR_W'(pop_s);
        count_d     = count_q + CNT_W'(push_lsu_s) + CNT_W'(push_alu_s) - CNT_W'(pop_s);
        gpr_wr_d    = pop_s;
        gpr_waddr_d = pop_s ? addr_q[head_q] : gpr_waddr_q;
        gpr_wd_d    = pop_s ? data_q[head_q] : gpr_wd_q;
    end

    // State registers; reset discards every pending entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            gpr_wr_q    <= 1'b0;
            gpr_waddr_q <= '0;
            gpr_wd_q    <= '0;
        end else begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            gpr_wr_q    <= gpr_wr_d;
            gpr_waddr_q <= gpr_waddr_d;
            gpr_wd_q    <= gpr_wd_d;
        end
    end

    // Forwarding: scan oldest (output stage) to youngest so the youngest match wins.
    always_comb begin
        fwd_hit0  = gpr_wr_q && (gpr_waddr_q == fwd_addr0);
        fwd_data0 = (gpr_wr_q && (gpr_waddr_q == fwd_addr0)) ? gpr_wd_q : '0;
        fwd_hit1  = gpr_wr_q && (gpr_waddr_q == fwd_addr1);
        fwd_data1 = (gpr_wr_q && (gpr_waddr_q == fwd_addr1)) ? gpr_wd_q : '0;
        for (int k = 0; k < Q_DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) && (addr_q[head_q + PTR_W'(k)] == fwd_addr0)) begin
                fwd_hit0  = 1'b1;
                fwd_data0 = data_q[head_q + PTR_W'(k)];
            end else begin
                fwd_hit0  = fwd_hit0;
                fwd_data0 = fwd_data0;
            end
            if ((CNT_W'(k) < count_q) && (addr_q[head_q + PTR_W'(k)] == fwd_addr1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = data_q[head_q + PTR_W'(k)];
            end else begin
                fwd_hit1  = fwd_hit1;
                fwd_data1 = fwd_data1;
            end
        end
    end

    assign gpr_wr    = gpr_wr_q;
    assign gpr_waddr = gpr_waddr_q;
    assign gpr_wd    = gpr_wd_q;
    assign wb_idle   = (count_q == '0) && !gpr_wr_q;

endmodule

// File: tb/tb_gpr_wb_unit.sv
// Directed bench for gpr_wb_unit: driver pushes expected GPR writes into a queue,
// an independent monitor pops and compares every cycle the DUT asserts gpr_wr.
module tb_gpr_wb_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, lsu_ready, alu_valid, alu_ready;
    logic [4:0]  lsu_addr, alu_addr, gpr_waddr, fwd_addr0, fwd_addr1;
    logic [31:0] lsu_data, alu_data, gpr_wd, fwd_data0, fwd_data1;
    logic        gpr_wr, fwd_hit0, fwd_hit1, wb_idle;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  mc    = 0;
    int  pend  = 0;

    always #5 clk = ~clk;

    gpr_wb_unit dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .gpr_wr(gpr_wr), .gpr_waddr(gpr_waddr), .gpr_wd(gpr_wd),
        .fwd_addr0(fwd_addr0), .fwd_addr1(fwd_addr1),
        .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
        .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
        .wb_idle(wb_idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one cycle of requests; readies are checked against an occupancy model.
    task automatic drive(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad);
        int  free;
        logic elr, ear;
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        #1;
        free = 4 - mc;
        elr  = (free >= 1);
        ear  = (free >= 2) || (free == 1 && !lv);
        chk("lsu_ready", lsu_ready, elr);
        chk("alu_ready", alu_ready, ear);
        pend = 0;
        if (lv && elr) begin sb.push_back({la, ld}); pend++; end
        if (av && ear) begin sb.push_back({aa, ad}); pend++; end
    endtask

    task automatic step();
        @(posedge clk);
        mc   = mc + pend - ((mc > 0) ? 1 : 0);
        pend = 0;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
    endtask

    // Monitor: every cycle with gpr_wr high must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && gpr_wr) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_write: got addr %0d data %h expected none", gpr_waddr, gpr_wd);
                end else begin
                    e = sb.pop_front();
                    chk("wb_addr", 32'(gpr_waddr), 32'(e.a));
                    chk("wb_data", gpr_wd, e.d);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        lsu_valid = 1'b0; lsu_addr = 5'd0; lsu_data = 32'd0;
        alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
        fwd_addr0 = 5'd0; fwd_addr1 = 5'd0;
        #1;
        chk("rst_gpr_wr", gpr_wr, 1'b0);
        chk("rst_waddr", 32'(gpr_waddr), 32'd0);
        chk("rst_wd", gpr_wd, 32'd0);
        chk("rst_idle", wb_idle, 1'b1);
        chk("rst_lsu_ready", lsu_ready, 1'b0);
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_fwd_hit", fwd_hit0, 1'b0);
        chk("rst_fwd_data", fwd_data0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single ALU write r3
        fwd_addr0 = 5'd3;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h12345678);
        chk("t1_fwd_pre", fwd_hit0, 1'b0);
        step();
        chk("t1_fwd_e0_hit", fwd_hit0, 1'b1);
        chk("t1_fwd_e0_data", fwd_data0, 32'h12345678);
        chk("t1_wr_e0", gpr_wr, 1'b0);
        chk("t1_idle_e0", wb_idle, 1'b0);
        idle();
        chk("t1_wr_e1", gpr_wr, 1'b1);
        chk("t1_waddr_e1", 32'(gpr_waddr), 32'd3);
        chk("t1_fwd_e1_hit", fwd_hit0, 1'b1);
        idle();
        chk("t1_wr_e2", gpr_wr, 1'b0);
        chk("t1_idle_e2", wb_idle, 1'b1);
        chk("t1_fwd_e2_hit", fwd_hit0, 1'b0);
        chk("t1_fwd_e2_data", fwd_data0, 32'd0);

        // Forward miss, including a same-cycle request that is not yet enqueued
        fwd_addr0 = 5'd9; fwd_addr1 = 5'd9;
        drive(1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0, 32'd0);
        chk("miss_hit0", fwd_hit0, 1'b0);
        chk("miss_data0", fwd_data0, 32'd0);
        chk("miss_hit1", fwd_hit1, 1'b0);
        step();
        chk("r9_hit1", fwd_hit1, 1'b1);
        chk("r9_data1", fwd_data1, 32'h00000099);
        idle();
        idle();

        // Same address from both sources: LSU older, ALU younger
        fwd_addr0 = 5'd5;
        drive(1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd5, 32'h0000BBBB);
        step();
        chk("t2_fwd_both", fwd_data0, 32'h0000BBBB);
        idle();
        chk("t2_fwd_alu_q", fwd_data0, 32'h0000BBBB);
        idle();
        chk("t2_fwd_out", fwd_data0, 32'h0000BBBB);
        chk("t2_fwd_out_hit", fwd_hit0, 1'b1);
        idle();
        chk("t2_fwd_gone", fwd_hit0, 1'b0);

        // Fill with both sources valid every cycle; pointers wrap several times
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'(10 + 2 * i), 32'hC0000000 + 32'(i),
                  1'b1, 5'(11 + 2 * i), 32'hD0000000 + 32'(i));
            if (i >= 2) begin
                chk("fill_lsu_ready_c3", lsu_ready, 1'b1);
                chk("fill_alu_blocked_c3", alu_ready, 1'b0);
            end
            step();
        end

        // free==1 with LSU idle: ALU takes the last slot
        fwd_addr1 = 5'd7;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h00000007);
        chk("free1_alu_ready", alu_ready, 1'b1);
        step();
        chk("r7_fwd_hit", fwd_hit1, 1'b1);
        chk("r7_fwd_data", fwd_data1, 32'h00000007);

        // Reset with three entries pending and a write in flight
        chk("pre_rst_wr", gpr_wr, 1'b1);
        lsu_valid = 1'b0; alu_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_wr", gpr_wr, 1'b0);
        chk("rst_mid_idle", wb_idle, 1'b1);
        chk("rst_mid_lsu_ready", lsu_ready, 1'b0);
        chk("rst_mid_alu_ready", alu_ready, 1'b0);
        chk("rst_mid_fwd", fwd_hit1, 1'b0);
        sb.delete();
        mc = 0;
        pend = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fwd_addr0 = 5'd4;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h00000044);
        step();
        chk("post_rst_fwd", fwd_hit0, 1'b1);
        for (int i = 0; i < 5; i++) idle();
        chk("post_rst_idle", wb_idle, 1'b1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
